seq_decoder: RTL and testbench
==============================

SEQ_DECODER -- requirements
Module: seq_decoder

Interface
REQ-001 SHALL have parameter N, default 3, meaning select width; legal N >= 1; output width W = 2^N.
REQ-002 SHALL have parameter DWELL, default 1, meaning accepted steps per position in scan modes; legal DWELL >= 1.
REQ-003 SHALL have parameter ACTIVE_LOW, default 0, meaning 1 inverts every bit of y (selected bit 0, others 1).
REQ-004 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-006 SHALL have port en, input, 1, output enable and scan enable.
REQ-007 SHALL have port mode, input, 2, operating mode: 00 DIRECT, 01 SCAN_UP, 10 SCAN_DOWN, 11 PINGPONG.
REQ-008 SHALL have port load, input, 1, loads sel into the index register.
REQ-009 SHALL have port sel, input, N, index to load.
REQ-010 SHALL have port step, input, 1, advance request in scan modes.
REQ-011 SHALL have port y, output, W, one-hot decoded output (polarity per ACTIVE_LOW).
REQ-012 SHALL have port idx, output, N, current index register.
REQ-013 SHALL have port wrap, output, 1, single-cycle pulse on wrap-around or pingpong reversal.

Function
REQ-014 SHALL hold registered state: idx (N bits), dwell counter cnt (ceil(log2(DWELL)) bits, minimum 1), direction dir (0 = up, 1 = down), en_q, mode_q, wrap.
REQ-015 SHALL drive y only from registers: y[i] active iff en_q = 1 and i = idx; no combinational path from any input to any output.
REQ-016 SHALL update en_q <= en and mode_q <= mode every non-reset cycle.
REQ-017 SHALL apply priority per edge: rst, then load, then mode change, then step.
REQ-018 On load = 1: idx <= sel, cnt <= 0, wrap <= 0; step ignored that cycle; allowed in any mode and with en = 0.
REQ-019 On mode != mode_q (no load): cnt <= 0, wrap <= 0, no advance that cycle; entering SCAN_UP sets dir <= 0, SCAN_DOWN sets dir <= 1, PINGPONG keeps dir.
REQ-020 In DIRECT: idx and cnt hold; step ignored.
REQ-021 In a scan mode, a step is accepted only when en = 1 and step = 1; with en = 0, idx, cnt and dir hold.
REQ-022 On an accepted step with cnt < DWELL-1: cnt <= cnt+1 and idx holds.
REQ-023 On an accepted step with cnt = DWELL-1: cnt <= 0 and idx advances; with DWELL = 1, every accepted step advances.
REQ-024 SCAN_UP advance: idx <= idx+1 mod W; wrap <= 1 iff idx was W-1 (next idx 0).
REQ-025 SCAN_DOWN advance: idx <= idx-1 mod W; wrap <= 1 iff idx was 0 (next idx W-1).
REQ-026 PINGPONG advance: with dir = 0 and idx = W-1: idx <= W-2, dir <= 1, wrap <= 1; with dir = 1 and idx = 0: idx <= 1, dir <= 0, wrap <= 1; otherwise move one step in dir with wrap <= 0.
REQ-027 PINGPONG with N = 1 SHALL alternate 0, 1, 0, ..., pulsing wrap on every advance.
REQ-028 wrap SHALL be 0 on every cycle without a qualifying advance, so it is high for exactly one cycle per event.
REQ-029 Latency: a load or advance at edge k SHALL be visible on idx and y immediately after edge k; en affects y one cycle later via en_q.

Reset
REQ-030 On rst = 1 at an edge: idx <= 0, cnt <= 0, dir <= 0, en_q <= 0, mode_q <= 00, wrap <= 0; y all inactive (all 0, or all 1 if ACTIVE_LOW).
REQ-031 rst SHALL override load, step and mode change in the same cycle, including mid-dwell and mid-pingpong.
REQ-032 After rst deasserts, the first cycle with mode != 00 SHALL be treated as a mode change per REQ-019.

Verification
REQ-033 N=3, DWELL=1, ACTIVE_LOW=0: reset, en=1, mode=00, load sel=5 -> next cycle idx=5, y=8'b0010_0000; steps ignored.
REQ-034 SCAN_UP, DWELL=1, load 6, step held high -> idx 6, 7, 0, 1; wrap high only on the 7->0 cycle.
REQ-035 SCAN_DOWN, DWELL=2, from idx 1, step high -> idx 1, 1, 0, 0, 7; wrap pulses once on the 0->7 advance.
REQ-036 PINGPONG, DWELL=1, from idx 6, dir up -> 6, 7, 6, 5; wrap on the 7->6 reversal; also from idx 1, dir down -> 1, 0, 1 with wrap on the 0->1 reversal.
REQ-037 Load and step in the same cycle in SCAN_UP with cnt=1, DWELL=3 -> idx=sel, cnt=0, wrap=0; en=0 -> y all 0 next cycle and idx frozen despite step.
REQ-038 rst asserted mid-scan together with load=1 -> idx=0, y=0, wrap=0; with ACTIVE_LOW=1, y=8'hFF after reset and y=8'b1111_1011 with en=1 and idx=2.

Source files
------------

// File: rtl/seq_decoder.sv
// One-hot decoder driven by a registered index that can be loaded directly or
// scanned up, down or ping-pong, with a per-position dwell count and a wrap pulse.
module seq_decoder #(
  parameter int N          = 3,
  parameter int DWELL      = 1,
  parameter bit ACTIVE_LOW = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [1:0]        mode,
  input  logic              load,
  input  logic [N-1:0]      sel,
  input  logic              step,
  output logic [(1<<N)-1:0] y,
  output logic [N-1:0]      idx,
  output logic              wrap
);

  localparam int W  = 1 << N;
  localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;

  localparam logic [1:0] MODE_DIRECT    = 2'b00;
  localparam logic [1:0] MODE_SCAN_UP   = 2'b01;
  localparam logic [1:0] MODE_SCAN_DOWN = 2'b10;
  localparam logic [1:0] MODE_PINGPONG  = 2'b11;

  localparam logic [N-1:0]  IDX_ONE  = N'(1);
  localparam logic [N-1:0]  IDX_MAX  = N'(W - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DWELL - 1);

  logic [CW-1:0] cnt;
  logic          dir;
  logic          en_q;
  logic [1:0]    mode_q;

  logic [N-1:0]  next_idx;
  logic          next_dir;
  logic          next_wrap;
  logic          step_ok;
  logic [W-1:0]  y_act;

  assign step_ok = (mode != MODE_DIRECT) && en && step;

  // NOTE: every output of an always_comb gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    next_idx  = idx;
    next_dir  = dir;
    next_wrap = 1'b0;
    case (mode)
      MODE_SCAN_UP: begin
        next_idx  = idx + IDX_ONE;
        next_wrap = (idx == IDX_MAX);
      end
      MODE_SCAN_DOWN: begin
        next_idx  = idx - IDX_ONE;
        next_wrap = (idx == '0);
      end
      MODE_PINGPONG: begin
        if (!dir && idx == IDX_MAX) begin
          next_idx  = IDX_MAX - IDX_ONE;
          next_dir  = 1'b1;
          next_wrap = 1'b1;
        end else if (dir && idx == '0) begin
          next_idx  = IDX_ONE;
          next_dir  = 1'b0;
          next_wrap = 1'b1;
        end else begin
          next_idx = dir ? idx - IDX_ONE : idx + IDX_ONE;
        end
      end
      default: ;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx    <= '0;
      cnt    <= '0;
      dir    <= 1'b0;
      en_q   <= 1'b0;
      mode_q <= MODE_DIRECT;
      wrap   <= 1'b0;
    end else begin
      en_q   <= en;
      mode_q <= mode;
      wrap   <= 1'b0;
      if (load) begin
        idx <= sel;
        cnt <= '0;
      end else if (mode != mode_q) begin
        // A mode change only re-arms the dwell count; movement starts next cycle.
        cnt <= '0;
        if (mode == MODE_SCAN_UP)   dir <= 1'b0;
        if (mode == MODE_SCAN_DOWN) dir <= 1'b1;
      end else if (step_ok) begin
        if (cnt != CNT_LAST) begin
          cnt <= cnt + CNT_ONE;
        end else begin
          cnt  <= '0;
          idx  <= next_idx;
          dir  <= next_dir;
          wrap <= next_wrap;
        end
      end
    end
  end

  // Decode only from registered state, so y has no path from any input.
  always_comb begin
    y_act      = '0;
    y_act[idx] = en_q;
  end

  assign y = ACTIVE_LOW ? ~y_act : y_act;

endmodule

// File: tb/tb_seq_decoder.sv
// Self-checking bench: five parameter variants share one stimulus stream and are
// compared every cycle against a behavioural model, plus directed scenario checks.
module tb_seq_decoder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, en, load, step;
  logic [1:0] mode;
  logic [2:0] sel;

  logic [7:0] y_o   [4];
  logic [2:0] idx_o [4];
  logic       wrap_o[4];
  logic [1:0] y_e;
  logic       idx_e, wrap_e;

  seq_decoder #(.N(3), .DWELL(1), .ACTIVE_LOW(1'b0)) u_a (.clk(clk), .rst(rst), .en(en), .mode(mode),
    .load(load), .sel(sel), .step(step), .y(y_o[0]), .idx(idx_o[0]), .wrap(wrap_o[0]));
  seq_decoder #(.N(3), .DWELL(2), .ACTIVE_LOW(1'b0)) u_b (.clk(clk), .rst(rst), .en(en), .mode(mode),
    .load(load), .sel(sel), .step(step), .y(y_o[1]), .idx(idx_o[1]), .wrap(wrap_o[1]));
  seq_decoder #(.N(3), .DWELL(3), .ACTIVE_LOW(1'b0)) u_c (.clk(clk), .rst(rst), .en(en), .mode(mode),
    .load(load), .sel(sel), .step(step), .y(y_o[2]), .idx(idx_o[2]), .wrap(wrap_o[2]));
  seq_decoder #(.N(3), .DWELL(1), .ACTIVE_LOW(1'b1)) u_d (.clk(clk), .rst(rst), .en(en), .mode(mode),
    .load(load), .sel(sel), .step(step), .y(y_o[3]), .idx(idx_o[3]), .wrap(wrap_o[3]));
  seq_decoder #(.N(1), .DWELL(2), .ACTIVE_LOW(1'b0)) u_e (.clk(clk), .rst(rst), .en(en), .mode(mode),
    .load(load), .sel(sel[0]), .step(step), .y(y_e), .idx(idx_e), .wrap(wrap_e));

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Model: per-variant parameters and abstract state held as plain integers.
  int p_n [5] = '{3, 3, 3, 3, 1};
  int p_d [5] = '{1, 2, 3, 1, 2};
  int p_al[5] = '{0, 0, 0, 1, 0};
  int m_idx[5], m_cnt[5], m_dir[5], m_enq[5], m_modeq[5], m_wrap[5];

  task automatic model_edge();
    for (int k = 0; k < 5; k++) begin
      int w;
      w = 1 << p_n[k];
      if (rst) begin
        m_idx[k] = 0; m_cnt[k] = 0; m_dir[k] = 0;
        m_enq[k] = 0; m_modeq[k] = 0; m_wrap[k] = 0;
      end else begin
        m_wrap[k] = 0;
        if (load) begin
          m_idx[k] = int'(sel) % w;
          m_cnt[k] = 0;
        end else if (int'(mode) != m_modeq[k]) begin
          m_cnt[k] = 0;
          if (mode == 2'd1) m_dir[k] = 0;
          if (mode == 2'd2) m_dir[k] = 1;
        end else if (mode != 2'd0 && en && step) begin
          if (m_cnt[k] < p_d[k] - 1) begin
            m_cnt[k]++;
          end else begin
            m_cnt[k] = 0;
            case (mode)
              2'd1: begin
                m_wrap[k] = (m_idx[k] == w - 1) ? 1 : 0;
                m_idx[k]  = (m_idx[k] + 1) % w;
              end
              2'd2: begin
                m_wrap[k] = (m_idx[k] == 0) ? 1 : 0;
                m_idx[k]  = (m_idx[k] + w - 1) % w;
              end
              default: begin
                if (m_dir[k] == 0 && m_idx[k] == w - 1) begin
                  m_idx[k] = w - 2; m_dir[k] = 1; m_wrap[k] = 1;
                end else if (m_dir[k] == 1 && m_idx[k] == 0) begin
                  m_idx[k] = 1; m_dir[k] = 0; m_wrap[k] = 1;
                end else begin
                  m_idx[k] = m_idx[k] + (m_dir[k] ? -1 : 1);
                end
              end
            endcase
          end
        end
        m_enq[k]   = int'(en);
        m_modeq[k] = int'(mode);
      end
    end
  endtask

  task automatic compare_all();
    for (int k = 0; k < 5; k++) begin
      int exp_y, obs_y, obs_idx, obs_wrap, w;
      w      = 1 << p_n[k];
      exp_y  = m_enq[k] ? (1 << m_idx[k]) : 0;
      if (p_al[k] != 0) exp_y = exp_y ^ ((1 << w) - 1);
      obs_y    = (k < 4) ? int'(y_o[k])    : int'(y_e);
      obs_idx  = (k < 4) ? int'(idx_o[k])  : int'(idx_e);
      obs_wrap = (k < 4) ? int'(wrap_o[k]) : int'(wrap_e);
      check($sformatf("u%0d_idx", k),  32'(obs_idx),  32'(m_idx[k]));
      check($sformatf("u%0d_y", k),    32'(obs_y),    32'(exp_y));
      check($sformatf("u%0d_wrap", k), 32'(obs_wrap), 32'(m_wrap[k]));
    end
  endtask

  task automatic cycle(input logic r, input logic e, input logic [1:0] m,
                       input logic l, input logic [2:0] s, input logic st);
    rst = r; en = e; mode = m; load = l; sel = s; step = st;
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; mode = 2'd0; load = 1'b0; sel = '0; step = 1'b0;

    cycle(1, 0, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0, 0);
    check("rst_idx", 32'(idx_o[0]), 32'd0);
    check("rst_y_high", 32'(y_o[3]), 32'hFF);

    // Direct load, steps ignored in DIRECT.
    cycle(0, 1, 0, 1, 3'd5, 0);
    check("direct_idx", 32'(idx_o[0]), 32'd5);
    check("direct_y", 32'(y_o[0]), 32'h20);
    cycle(0, 1, 0, 0, 3'd0, 1);
    cycle(0, 1, 0, 0, 3'd0, 1);
    check("direct_hold", 32'(idx_o[0]), 32'd5);

    // Scan up across the top, DWELL=1.
    cycle(0, 1, 1, 1, 3'd6, 0);
    check("up_load", 32'(idx_o[0]), 32'd6);
    cycle(0, 1, 1, 0, 3'd0, 1);
    check("up_7", 32'(idx_o[0]), 32'd7);
    check("up_7_wrap", 32'(wrap_o[0]), 32'd0);
    cycle(0, 1, 1, 0, 3'd0, 1);
    check("up_0", 32'(idx_o[0]), 32'd0);
    check("up_0_wrap", 32'(wrap_o[0]), 32'd1);
    cycle(0, 1, 1, 0, 3'd0, 1);
    check("up_1", 32'(idx_o[0]), 32'd1);
    check("up_1_wrap", 32'(wrap_o[0]), 32'd0);

    // Scan down across the bottom, DWELL=2.
    cycle(0, 1, 2, 1, 3'd1, 0);
    check("dn_load", 32'(idx_o[1]), 32'd1);
    cycle(0, 1, 2, 0, 3'd0, 1);
    check("dn_dwell", 32'(idx_o[1]), 32'd1);
    cycle(0, 1, 2, 0, 3'd0, 1);
    check("dn_0", 32'(idx_o[1]), 32'd0);
    cycle(0, 1, 2, 0, 3'd0, 1);
    check("dn_0_hold", 32'(idx_o[1]), 32'd0);
    cycle(0, 1, 2, 0, 3'd0, 1);
    check("dn_7", 32'(idx_o[1]), 32'd7);
    check("dn_7_wrap", 32'(wrap_o[1]), 32'd1);

    // Ping-pong reversal at both ends.
    cycle(0, 1, 1, 0, 3'd0, 0);
    cycle(0, 1, 3, 1, 3'd6, 0);
    cycle(0, 1, 3, 0, 3'd0, 1);
    check("pp_7", 32'(idx_o[0]), 32'd7);
    cycle(0, 1, 3, 0, 3'd0, 1);
    check("pp_6", 32'(idx_o[0]), 32'd6);
    check("pp_top_wrap", 32'(wrap_o[0]), 32'd1);
    cycle(0, 1, 3, 0, 3'd0, 1);
    check("pp_5", 32'(idx_o[0]), 32'd5);
    cycle(0, 1, 3, 1, 3'd1, 0);
    cycle(0, 1, 3, 0, 3'd0, 1);
    check("pp_0", 32'(idx_o[0]), 32'd0);
    cycle(0, 1, 3, 0, 3'd0, 1);
    check("pp_1", 32'(idx_o[0]), 32'd1);
    check("pp_bot_wrap", 32'(wrap_o[0]), 32'd1);

    // Load beats a mid-dwell step; en=0 freezes and blanks.
    cycle(0, 1, 1, 1, 3'd0, 0);
    cycle(0, 1, 1, 0, 3'd0, 1);
    cycle(0, 1, 1, 1, 3'd4, 1);
    check("ld_step_idx", 32'(idx_o[2]), 32'd4);
    check("ld_step_wrap", 32'(wrap_o[2]), 32'd0);
    cycle(0, 0, 1, 0, 3'd0, 1);
    check("en0_idx", 32'(idx_o[2]), 32'd4);
    check("en0_y", 32'(y_o[2]), 32'd0);

    // Reset wins over load mid-scan; active-low decode.
    cycle(0, 1, 3, 0, 3'd0, 1);
    cycle(0, 1, 3, 0, 3'd0, 1);
    cycle(1, 1, 3, 1, 3'd5, 1);
    check("rst_ld_idx", 32'(idx_o[0]), 32'd0);
    check("rst_ld_y", 32'(y_o[0]), 32'd0);
    check("rst_ld_y_high", 32'(y_o[3]), 32'hFF);
    cycle(0, 1, 0, 1, 3'd2, 0);
    check("al_y", 32'(y_o[3]), 32'hFB);

    // Randomized phase.
    for (int i = 0; i < 600; i++) begin
      logic [1:0] m;
      m = mode;
      if ($urandom_range(0, 7) == 0) m = 2'($urandom_range(0, 3));
      cycle($urandom_range(0, 49) == 0, $urandom_range(0, 3) != 0, m,
            $urandom_range(0, 11) == 0, 3'($urandom_range(0, 7)),
            $urandom_range(0, 3) != 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
